// File: rtl/bch_pkg.sv
// Shared BCH(63,51) t=2 definitions for the encoder/decoder pair over GF(2^6),
// primitive polynomial x^6+x+1.
package bch_pkg;

    localparam int BCH_N    = 63;
    localparam int BCH_K    = 51;
    localparam int BCH_NPAR = 12;

    // Generator g(x) = m1*m3 = x^12+x^10+x^8+x^5+x^4+x^3+1; x^12 term implicit.
    localparam logic [BCH_NPAR-1:0] GEN_LOW = 12'h539;

    typedef enum logic [0:0] {
        ST_MSG    = 1'b0,
        ST_PARITY = 1'b1
    } t_bch_enc_state;

    // Polynomial-basis multiply; x^6 folds back to x+1.
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p;
        logic [5:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[4:0], 1'b0} ^ (t[5] ? 6'h03 : 6'h00);
        end
        return p;
    endfunction

    // a^-1 = a^62 in GF(2^6)*; maps 0 to 0.
    function automatic logic [5:0] gf_inv(input logic [5:0] a);
        logic [5:0] r;
        r = 6'h01;
        for (int i = 0; i < 62; i++) r = gf_mul(r, a);
        return r;
    endfunction

endpackage

// File: rtl/bch_parity_lfsr.sv
// 12-bit division LFSR computing the remainder of m(x)*x^12 mod g(x).
// With feed_en low it shifts the remainder out MSB first without feedback.
module bch_parity_lfsr
    import bch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic shift,
    input  logic feed_en,
    input  logic din,
    input  logic clear,
    output logic msb
);

    logic [BCH_NPAR-1:0] par;
    logic                fb;

    assign fb  = feed_en && (din ^ par[BCH_NPAR-1]);
    assign msb = par[BCH_NPAR-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= '0;
        end else if (clear) begin
            par <= '0;
        end else if (shift) begin
            par <= {par[BCH_NPAR-2:0], 1'b0} ^ (fb ? GEN_LOW : '0);
        end
    end

endmodule

// File: rtl/bch_encoder.sv
// Serial systematic BCH(63,51) encoder: echoes 51 message bits, then emits
// 12 parity bits, MSB (x^62) first, with valid/ready on both sides.
module bch_encoder
    import bch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_data,
    output logic in_ready,
    output logic out_valid,
    output logic out_data,
    input  logic out_ready
);

    localparam logic [5:0] MSG_LAST = 6'(BCH_K - 1);
    localparam logic [5:0] PAR_LAST = 6'(BCH_NPAR - 1);

    t_bch_enc_state state;
    logic [5:0]     cnt;
    logic           free;
    logic           accept;
    logic           par_step;
    logic           par_msb;

    assign free     = !out_valid || out_ready;
    assign in_ready = (state == ST_MSG) && free;
    assign accept   = in_valid && in_ready;
    assign par_step = (state == ST_PARITY) && free;

    // Remainder is already zero after the 12th parity shift; clearing also
    // guarantees a clean start if anything upstream ever misbehaves.
    bch_parity_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift   (accept || par_step),
        .feed_en (state == ST_MSG),
        .din     (in_data),
        .clear   (par_step && (cnt == PAR_LAST)),
        .msb     (par_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_MSG;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
        end else begin
            unique case (state)
                ST_MSG: begin
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        if (cnt == MSG_LAST) begin
                            cnt   <= '0;
                            state <= ST_PARITY;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end else if (free) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_PARITY: begin
                    if (free) begin
                        out_data  <= par_msb;
                        out_valid <= 1'b1;
                        if (cnt == PAR_LAST) begin
                            cnt   <= '0;
                            state <= ST_MSG;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                default: state <= ST_MSG;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_encoder.sv
// Self-checking bench for bch_encoder: hand-computed vector table, throttled
// random streams against a long-division golden encoder, and reset corners.
module tb_bch_encoder;
    import bch_pkg::*;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_data, in_ready, out_valid, out_data, out_ready;

    bch_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [50:0] msg;
        logic [11:0] par;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          out_q[$];
    logic [50:0] stream_msgs[$];
    bit          prev_stall;
    logic        prev_data;
    int          cyc_idx, low_cnt, first_low, run, max_run;

    task automatic check(input string name, input logic [62:0] got, input logic [62:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Golden parity by polynomial long division of m(x)*x^12 by g(x).
    function automatic logic [11:0] golden_par(input logic [50:0] m);
        logic [62:0] r;
        r = {m, 12'b0};
        for (int i = 62; i >= 12; i--)
            if (r[i]) r[i -: 13] = r[i -: 13] ^ 13'h1539;
        return r[11:0];
    endfunction

    function automatic logic [5:0] syndrome(input logic [62:0] c, input logic [5:0] a);
        logic [5:0] s;
        s = '0;
        for (int i = 62; i >= 0; i--) s = gf_mul(s, a) ^ {5'b0, c[i]};
        return s;
    endfunction

    task automatic cycle(input logic iv, input logic id, input logic orr, output logic acc);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = id;
        out_ready = orr;
        @(negedge clk);
        cyc_idx++;
        acc = iv && in_ready;
        if (prev_stall)
            check("stall_hold", 63'({out_valid, out_data}), 63'({1'b1, prev_data}));
        if (out_valid && out_ready) out_q.push_back(out_data);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (!in_ready) begin
            low_cnt++;
            if (first_low == 0) first_low = cyc_idx;
        end
        if (out_valid) begin
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    endtask

    // Streams every message in stream_msgs; pv/pr are percent duty of in_valid/out_ready.
    task automatic run_stream(input int pv, input int pr);
        int   n, total, bit_idx, budget;
        logic iv, id, orr, acc;
        n       = stream_msgs.size();
        total   = BCH_K * n;
        budget  = 63 * n * 10 + 200;
        bit_idx = 0;
        out_q.delete();
        prev_stall = 0;
        cyc_idx = 0; low_cnt = 0; first_low = 0; run = 0; max_run = 0;
        while ((bit_idx < total || out_q.size() < 63 * n) && cyc_idx < budget) begin
            iv  = (bit_idx < total) && ($urandom_range(99) < pv);
            id  = iv ? stream_msgs[bit_idx / BCH_K][50 - (bit_idx % BCH_K)] : 1'b0;
            orr = $urandom_range(99) < pr;
            cycle(iv, id, orr, acc);
            if (acc) bit_idx++;
        end
        if (cyc_idx >= budget) check("stream_timeout", 63'(cyc_idx), 63'(0));
    endtask

    task automatic drain_and_count(input int n);
        logic acc;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, acc);
        check("bit_count", 63'(out_q.size()), 63'(63 * n));
    endtask

    function automatic logic [62:0] got_cw(input int k);
        logic [62:0] g;
        g = '0;
        for (int j = 0; j < 63; j++)
            if (63 * k + j < out_q.size()) g = {g[61:0], out_q[63 * k + j]};
        return g;
    endfunction

    initial begin
        vec_t        vecs[5];
        logic [62:0] cw;
        logic        acc;
        int          bad;

        vecs[0] = '{msg: 51'd0, par: 12'h000};
        vecs[1] = '{msg: 51'd1, par: 12'h539};
        vecs[2] = '{msg: 51'd2, par: 12'hA72};
        vecs[3] = '{msg: 51'd4, par: 12'h1DD};
        vecs[4] = '{msg: 51'd3, par: 12'hF4B};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 63'({out_valid, out_data, in_ready}), 63'(3'b001));
        @(negedge clk);
        rst_n = 1'b1;

        bad = 0;
        for (int a = 1; a < 64; a++)
            if (gf_mul(6'(a), gf_inv(6'(a))) != 6'h01) bad++;
        check("gf_inverse", 63'(bad), 63'(0));

        // Hand-computed vectors, full rate.
        for (int i = 0; i < 5; i++) begin
            stream_msgs.delete();
            stream_msgs.push_back(vecs[i].msg);
            run_stream(100, 100);
            check($sformatf("vec%0d_codeword", i), got_cw(0), {vecs[i].msg, vecs[i].par});
            check($sformatf("vec%0d_ready_low", i), 63'(low_cnt), 63'(12));
            check($sformatf("vec%0d_first_low", i), 63'(first_low), 63'(52));
            check($sformatf("vec%0d_valid_run", i), 63'(max_run), 63'(63));
            drain_and_count(1);
        end

        // Three back-to-back codewords.
        stream_msgs.delete();
        for (int i = 0; i < 3; i++)
            stream_msgs.push_back({$urandom(), $urandom()} & {51{1'b1}});
        run_stream(100, 100);
        check("b2b_valid_run", 63'(max_run), 63'(189));
        check("b2b_ready_low", 63'(low_cnt), 63'(36));
        for (int k = 0; k < 3; k++)
            check($sformatf("b2b_cw%0d", k), got_cw(k), {stream_msgs[k], golden_par(stream_msgs[k])});
        drain_and_count(3);

        // Throttled random traffic on both sides.
        stream_msgs.delete();
        for (int i = 0; i < 6; i++)
            stream_msgs.push_back({$urandom(), $urandom()} & {51{1'b1}});
        run_stream(50, 50);
        for (int k = 0; k < 6; k++) begin
            cw = got_cw(k);
            check($sformatf("rnd_cw%0d", k), cw, {stream_msgs[k], golden_par(stream_msgs[k])});
            check($sformatf("rnd_syn%0d", k), 63'({syndrome(cw, 6'h02), syndrome(cw, 6'h08)}), 63'(0));
        end
        drain_and_count(6);

        // Reset after 20 message bits, then a fresh codeword.
        stream_msgs.delete();
        stream_msgs.push_back(51'h7_5A3C_9E1F_0B62);
        prev_stall = 0;
        for (int i = 0; i < 20; i++) cycle(1'b1, stream_msgs[0][50 - i], 1'b1, acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("reset_mid", 63'({out_valid, in_ready}), 63'(2'b01));
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(100, 100);
        check("post_reset_cw", got_cw(0), {stream_msgs[0], golden_par(stream_msgs[0])});
        drain_and_count(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
